// File: rtl/adrv9009_pkg.sv
// adrv9009_pkg
// Constants and encodings shared by the ADRV9009 transmit and receive FIR paths.
//   DW        : sample and coefficient width (signed Q1.15)
//   MAX_TAPS  : coefficient RAM depth and delay-line length
//   ACC_W     : MAC accumulator width, 2*DW + ceil(log2(MAX_TAPS))
//   Q15_SHIFT : right shift that returns a Q1.15 product sum to sample scale
package adrv9009_pkg;

  localparam int DW        = 16;
  localparam int MAX_TAPS  = 48;
  localparam int ACC_W     = 38;
  localparam int Q15_SHIFT = 15;
  localparam int ADDR_W    = 7;
  localparam int IDX_W     = $clog2(MAX_TAPS);
  localparam int TAPS_24   = 24;

  typedef enum logic [1:0] {
    TFIR_BYPASS    = 2'b00,
    TFIR_24T       = 2'b01,
    TFIR_48T       = 2'b10,
    TFIR_MODE_RSVD = 2'b11
  } tfir_mode_e;

  typedef enum logic [1:0] {
    TFIR_X1          = 2'b00,
    TFIR_X2          = 2'b01,
    TFIR_X4          = 2'b10,
    TFIR_INTERP_RSVD = 2'b11
  } tfir_interp_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tfir_state_e;

  // Last phase-counter value for an interpolation setting (L-1); the
  // reserved encoding behaves as x1.
  function automatic logic [1:0] last_phase(input tfir_interp_e interp);
    case (interp)
      TFIR_X2: return 2'd1;
      TFIR_X4: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/adrv9009_coeff_ram.sv
// adrv9009_coeff_ram
// Coefficient store for the Tx/Rx programmable FIRs: single write port,
// every tap readable at once (asynchronous read). Not reset, so a loaded
// filter survives a block reset.
//   clk_m    in   write clock
//   wr_en    in   write strobe (already qualified by the owner of the RAM)
//   addr_in  in   write address; addresses >= MAX_TAPS are dropped
//   coeff_in in   coefficient to store
//   taps     out  all MAX_TAPS coefficients, tap k at taps[k]
module adrv9009_coeff_ram
  import adrv9009_pkg::*;
(
  input  logic                           clk_m,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              addr_in,
  input  logic [DW-1:0]                  coeff_in,
  output logic [MAX_TAPS-1:0][DW-1:0]    taps
);

  logic [MAX_TAPS-1:0][DW-1:0] mem;

  // Full-width compare so that e.g. address 64 cannot alias onto tap 0.
  always_ff @(posedge clk_m) begin
    if (wr_en && (addr_in < ADDR_W'(MAX_TAPS))) begin
      mem[addr_in[IDX_W-1:0]] <= coeff_in;
    end
  end

  assign taps = mem;

endmodule

// File: rtl/adrv9009_tfir_interp.sv
// adrv9009_tfir_interp
// Transmit programmable FIR with 1x/2x/4x zero-stuffing interpolation.
// One input sample is taken every L cycles, one output leaves every cycle.
//   clk_m        in   sample clock
//   reset        in   synchronous active-high reset
//   en_tfir      in   filter enable; mode/interp latched when leaving IDLE
//   mode_tfir    in   00 bypass, 01 24 taps, 10 48 taps, 11 bypass
//   interp_tfir  in   00 x1, 01 x2, 10 x4, 11 x1
//   wr_en        in   coefficient write strobe (honoured only while disabled)
//   addr_in      in   coefficient address
//   coeff_in     in   Q1.15 coefficient
//   in/in_valid  in   input sample handshake, taken when in_ready is high
//   in_ready     out  block takes a sample this cycle
//   out          out  filtered sample
//   out_valid    out  out carries a filter sample
//   underrun     out  sticky: no sample offered on an input slot
//   sat_flag     out  sticky: output clipped
//
// state | meaning
// IDLE  | disabled: delay line zero, outputs zero, flags hold
// RUN   | filtering: phase counter runs, delay line shifts every cycle
module adrv9009_tfir_interp
  import adrv9009_pkg::*;
(
  input  logic              clk_m,
  input  logic              reset,
  input  logic              en_tfir,
  input  logic [1:0]        mode_tfir,
  input  logic [1:0]        interp_tfir,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DW-1:0]     coeff_in,
  input  logic [DW-1:0]     in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DW-1:0]     out,
  output logic              out_valid,
  output logic              underrun,
  output logic              sat_flag
);

  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  tfir_state_e                  state_q, state_d;
  tfir_mode_e                   mode_q;
  logic [1:0]                   phase_q, phase_last_q;
  logic                         run_d1_q;
  logic signed [DW-1:0]         dly_q [MAX_TAPS];
  logic [MAX_TAPS-1:0][DW-1:0]  taps;
  logic signed [ACC_W-1:0]      acc, acc_sh;
  logic [DW-1:0]                y;
  logic                         clip;

  adrv9009_coeff_ram u_coeff_ram (
    .clk_m    (clk_m),
    .wr_en    (wr_en && !en_tfir),
    .addr_in  (addr_in),
    .coeff_in (coeff_in),
    .taps     (taps)
  );

  // in_ready also requires en_tfir: on the cycle we leave RUN the delay
  // line is flushed, so a handshake there would silently lose a sample.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: if (en_tfir) state_d = ST_RUN;
      ST_RUN: begin
        in_ready = en_tfir && (phase_q == 2'd0);
        if (!en_tfir) state_d = ST_IDLE;
      end
    endcase
  end

  // Sign-extend both operands to ACC_W so the product is formed at full width.
  always_comb begin
    acc = '0;
    for (int k = 0; k < MAX_TAPS; k++) begin
      if ((k < TAPS_24) || (mode_q == TFIR_48T)) begin
        acc = acc + ACC_W'($signed(taps[k])) * ACC_W'(dly_q[k]);
      end
    end
    acc_sh = acc >>> Q15_SHIFT;
    y      = acc_sh[DW-1:0];
    clip   = 1'b0;
    if (acc_sh > SAT_HI) begin
      y    = SAT_HI[DW-1:0];
      clip = 1'b1;
    end else if (acc_sh < SAT_LO) begin
      y    = SAT_LO[DW-1:0];
      clip = 1'b1;
    end
    // Bypass is exact pass-through of the newest delay-line entry.
    if (mode_q == TFIR_BYPASS) begin
      y    = dly_q[0];
      clip = 1'b0;
    end
  end

  always_ff @(posedge clk_m) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= TFIR_BYPASS;
      phase_last_q <= 2'd0;
      phase_q      <= 2'd0;
      run_d1_q     <= 1'b0;
      out          <= '0;
      out_valid    <= 1'b0;
      underrun     <= 1'b0;
      sat_flag     <= 1'b0;
      for (int k = 0; k < MAX_TAPS; k++) dly_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_RUN) && en_tfir) begin
        phase_q <= (phase_q == phase_last_q) ? 2'd0 : phase_q + 2'd1;
        for (int k = MAX_TAPS-1; k > 0; k--) dly_q[k] <= dly_q[k-1];
        dly_q[0] <= (in_ready && in_valid) ? in : '0;
        if (in_ready && !in_valid) underrun <= 1'b1;
        if (clip) sat_flag <= 1'b1;
        out       <= y;
        out_valid <= run_d1_q;
        run_d1_q  <= 1'b1;
      end else begin
        phase_q   <= 2'd0;
        out       <= '0;
        out_valid <= 1'b0;
        run_d1_q  <= 1'b0;
        for (int k = 0; k < MAX_TAPS; k++) dly_q[k] <= '0;
        if ((state_q == ST_IDLE) && en_tfir) begin
          mode_q       <= (mode_tfir == TFIR_MODE_RSVD) ? TFIR_BYPASS : tfir_mode_e'(mode_tfir);
          phase_last_q <= last_phase(tfir_interp_e'(interp_tfir));
          underrun     <= 1'b0;
          sat_flag     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adrv9009_tfir_interp.sv
// Testbench for adrv9009_tfir_interp: directed vector tables plus short
// hand-written sequences around reset, write gating, mode latching and saturation.
module tb_adrv9009_tfir_interp;

  logic        clk_m = 1'b0;
  logic        reset;
  logic        en_tfir;
  logic [1:0]  mode_tfir;
  logic [1:0]  interp_tfir;
  logic        wr_en;
  logic [6:0]  addr_in;
  logic [15:0] coeff_in;
  logic [15:0] din;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out;
  logic        out_valid;
  logic        underrun;
  logic        sat_flag;

  adrv9009_tfir_interp dut (
    .clk_m       (clk_m),
    .reset       (reset),
    .en_tfir     (en_tfir),
    .mode_tfir   (mode_tfir),
    .interp_tfir (interp_tfir),
    .wr_en       (wr_en),
    .addr_in     (addr_in),
    .coeff_in    (coeff_in),
    .in          (din),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out         (out),
    .out_valid   (out_valid),
    .underrun    (underrun),
    .sat_flag    (sat_flag)
  );

  always #5 clk_m = ~clk_m;

  typedef struct {
    logic        vld;
    logic [15:0] din;
    int          exp_out;
    logic        exp_valid;
    logic        exp_ready;
    logic        exp_unr;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk_m);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic write_coeff(input int a, input int c);
    wr_en    = 1'b1;
    addr_in  = 7'(a);
    coeff_in = 16'(c);
    tick();
    wr_en    = 1'b0;
  endtask

  task automatic enable(input logic [1:0] m, input logic [1:0] l);
    mode_tfir   = m;
    interp_tfir = l;
    en_tfir     = 1'b1;
    in_valid    = 1'b0;
    tick();
    check("enable ready", int'(in_ready), 1);
    check("enable valid", int'(out_valid), 0);
    check("enable underrun", int'(underrun), 0);
    check("enable sat", int'(sat_flag), 0);
  endtask

  task automatic stop_run(input string nm);
    en_tfir  = 1'b0;
    in_valid = 1'b0;
    tick();
    check({nm, " idle out"}, int'($signed(out)), 0);
    check({nm, " idle valid"}, int'(out_valid), 0);
    check({nm, " idle ready"}, int'(in_ready), 0);
  endtask

  // c[k] = 2(k+1), impulse 0x4000: out = (k+1) one cycle after the tap
  // reaches d[k]. The sample is held while in_ready is low (x2 case).
  task automatic build_impulse(input int ntaps, input int l);
    tbl.delete();
    for (int i = 0; i < ntaps + 3; i++) begin
      vec_t v;
      v.vld       = 1'b1;
      v.din       = (i < l) ? 16'h4000 : 16'h0000;
      v.exp_out   = (i >= 1 && i <= ntaps) ? i : 0;
      v.exp_valid = (i >= 1);
      v.exp_ready = ((i % l) == 0);
      v.exp_unr   = 1'b0;
      tbl.push_back(v);
    end
  endtask

  // Bypass x4, 1234 offered every cycle except the phase-0 slot at record 8.
  task automatic build_bypass();
    tbl.delete();
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v.vld       = (i != 8);
      v.din       = 16'd1234;
      v.exp_out   = (i >= 1 && ((i - 1) % 4) == 0 && (i - 1) != 8) ? 1234 : 0;
      v.exp_valid = (i >= 1);
      v.exp_ready = ((i % 4) == 0);
      v.exp_unr   = (i >= 8);
      tbl.push_back(v);
    end
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      check($sformatf("%s[%0d] ready", nm, i), int'(in_ready), int'(tbl[i].exp_ready));
      in_valid = tbl[i].vld;
      din      = tbl[i].din;
      tick();
      check($sformatf("%s[%0d] out", nm, i), int'($signed(out)), tbl[i].exp_out);
      check($sformatf("%s[%0d] valid", nm, i), int'(out_valid), int'(tbl[i].exp_valid));
      check($sformatf("%s[%0d] underrun", nm, i), int'(underrun), int'(tbl[i].exp_unr));
    end
    in_valid = 1'b0;
    din      = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en_tfir = 1'b0; mode_tfir = 2'b00; interp_tfir = 2'b00;
    wr_en = 1'b0; addr_in = '0; coeff_in = '0; din = '0; in_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("reset out", int'($signed(out)), 0);
    check("reset valid", int'(out_valid), 0);
    check("reset ready", int'(in_ready), 0);
    check("reset underrun", int'(underrun), 0);
    check("reset sat", int'(sat_flag), 0);

    for (int k = 0; k < 48; k++) write_coeff(k, 2 * (k + 1));

    // 24 taps, x1
    enable(2'b01, 2'b00);
    build_impulse(24, 1);
    run_table("imp24x1");
    stop_run("imp24x1");

    // 24 taps, x2
    enable(2'b01, 2'b01);
    build_impulse(24, 2);
    run_table("imp24x2");
    stop_run("imp24x2");

    // writes while enabled and to out-of-range addresses must be dropped
    enable(2'b01, 2'b00);
    wr_en = 1'b1; addr_in = 7'd0; coeff_in = 16'h7fff;
    tick();
    tick();
    wr_en = 1'b0;
    check("starved underrun", int'(underrun), 1);
    stop_run("gate");
    write_coeff(60, 16'h7fff);
    write_coeff(64, 16'h7fff);
    enable(2'b01, 2'b00);
    build_impulse(24, 1);
    run_table("gate");
    stop_run("gate");

    // reset in the middle of a run
    enable(2'b01, 2'b00);
    in_valid = 1'b1; din = 16'h4000;
    tick();
    din = 16'h0000;
    tick();
    tick();
    check("pre_rst out", int'($signed(out)), 2);
    reset = 1'b1; en_tfir = 1'b0; in_valid = 1'b0;
    tick();
    check("mid_rst out", int'($signed(out)), 0);
    check("mid_rst valid", int'(out_valid), 0);
    check("mid_rst ready", int'(in_ready), 0);
    reset = 1'b0;
    tick();
    enable(2'b01, 2'b00);
    build_impulse(24, 1);
    run_table("post_rst");
    stop_run("post_rst");

    // mode change while enabled is ignored until re-enable
    enable(2'b01, 2'b00);
    mode_tfir = 2'b10;
    build_impulse(24, 1);
    run_table("latch24");
    stop_run("latch24");
    enable(2'b10, 2'b00);
    build_impulse(48, 1);
    run_table("imp48");
    stop_run("imp48");

    // bypass x4 with one missing sample
    enable(2'b00, 2'b10);
    build_bypass();
    run_table("byp4");
    stop_run("byp4");

    // saturation, 24 taps of 32767
    for (int k = 0; k < 24; k++) write_coeff(k, 32767);
    enable(2'b01, 2'b00);
    in_valid = 1'b1; din = 16'h7fff;
    tick();
    check("sat e1 out", int'($signed(out)), 0);
    tick();
    check("sat one tap out", int'($signed(out)), 32766);
    check("sat one tap flag", int'(sat_flag), 0);
    tick();
    check("sat two tap out", int'($signed(out)), 32767);
    check("sat two tap flag", int'(sat_flag), 1);
    repeat (30) tick();
    check("sat pos out", int'($signed(out)), 32767);
    check("sat pos valid", int'(out_valid), 1);
    din = 16'h8000;
    repeat (30) tick();
    check("sat neg out", int'($signed(out)), -32768);
    check("sat neg flag", int'(sat_flag), 1);
    stop_run("sat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
